// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - display-side bundle of the seven-segment scan driver
// Purpose: groups the value/mask inputs and the anode/segment outputs.
// Signals:
//   data    [31:0] hex value, nibble k drives digit k
//   dp_in   [7:0]  decimal point per digit, 1 = lit
//   en_mask [7:0]  per-digit enable, 1 = digit may light
//   an      [7:0]  digit anodes, active-low
//   seg     [6:0]  segments {g,f,e,d,c,b,a}, active-low
//   dp             decimal point, active-low
// Modports: master = value source / display, slave = scan driver.
interface seg7_scan_driver_if;
    logic [31:0] data;
    logic [7:0]  dp_in;
    logic [7:0]  en_mask;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output data, dp_in, en_mask,
        input  an, seg, dp
    );

    modport slave (
        input  data, dp_in, en_mask,
        output an, seg, dp
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed 8-digit common-anode hex display driver
// Purpose: edge-detects the divided scan_clk in the clk domain, steps a digit
//   index on each rising edge, inserts one blank cycle before every digit and
//   displays a per-frame snapshot of data/dp_in/en_mask.
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   scan_clk  divided clock, sampled as data only
//   bus       seg7_scan_driver_if.slave (data, dp_in, en_mask in; an, seg, dp out)
// Parameters: DIGITS (1..8), SYNC_STAGES (2 or 3)
// Optional macro: SEG7_LEADING_ZERO_BLANK_EN - suppress digits above the
//   highest nonzero nibble of the snapshot (digit 0 always eligible).
module seg7_scan_driver #(
    parameter int DIGITS      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               scan_clk,
    seg7_scan_driver_if.slave  bus
);
    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } phase_t;

    localparam logic [2:0] LAST_IDX = 3'(DIGITS - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_prev;
    logic [2:0]             r_idx;
    logic [31:0]            r_snap_data;
    logic [7:0]             r_snap_dp;
    logic [7:0]             r_snap_mask;
    phase_t                 r_phase;
    logic [7:0]             r_an;
    logic [6:0]             r_seg;
    logic                   r_dp;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [2:0]             r_top;
`endif

    logic       w_step;
    logic [2:0] w_idx_next;
    logic [3:0] w_nibble;
    logic       w_lit;
    logic [7:0] w_an_drive;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    function automatic logic [2:0] top_nibble(input logic [31:0] d);
        logic [2:0] top;
        top = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (d[4*k +: 4] != 4'h0) begin
                top = 3'(k);
            end
        end
        return top;
    endfunction
`endif

    // Rising edge of the synchronized scan_clk only; falling edges ignored.
    assign w_step     = r_sync[SYNC_STAGES-1] & ~r_sync_prev;
    assign w_idx_next = (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;
    assign w_nibble   = r_snap_data[{r_idx, 2'b00} +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    assign w_lit = r_snap_mask[r_idx] & (r_idx <= r_top);
`else
    assign w_lit = r_snap_mask[r_idx];
`endif

    always_comb begin
        w_an_drive = 8'hFF;
        if (w_lit) begin
            w_an_drive[r_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync      <= '0;
            r_sync_prev <= 1'b0;
            r_idx       <= 3'd0;
            r_snap_data <= 32'h0;
            r_snap_dp   <= 8'h00;
            r_snap_mask <= 8'h00;
            r_phase     <= BLANK;
            r_an        <= 8'hFF;
            r_seg       <= 7'h7F;
            r_dp        <= 1'b1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            r_top       <= 3'd0;
`endif
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], scan_clk};
            r_sync_prev <= r_sync[SYNC_STAGES-1];
            if (w_step) begin
                // Blank for one cycle on every digit change (ghosting guard).
                r_idx   <= w_idx_next;
                r_phase <= BLANK;
                r_an    <= 8'hFF;
                r_seg   <= 7'h7F;
                r_dp    <= 1'b1;
                // Snapshot at frame start so a frame never mixes two values.
                if (w_idx_next == 3'd0) begin
                    r_snap_data <= bus.data;
                    r_snap_dp   <= bus.dp_in;
                    r_snap_mask <= bus.en_mask;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                    r_top       <= top_nibble(bus.data);
`endif
                end
            end else if (r_phase == BLANK) begin
                // seg/dp follow the decode even for masked digits.
                r_phase <= DRIVE;
                r_an    <= w_an_drive;
                r_seg   <= seg_decode(w_nibble);
                r_dp    <= ~r_snap_dp[r_idx];
            end
        end
    end

    assign bus.an  = r_an;
    assign bus.seg = r_seg;
    assign bus.dp  = r_dp;
endmodule
